// File: rtl/palette_load_seq.sv
// Palette load sequencer: turns palette commands plus a data stream into
// single-half writes, wrapping burst loads and a full-palette clear.
module palette_load_seq #(
  parameter int DATA_W = 16,
  parameter int SLOT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       cmd,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] data,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              pal_we,
  output logic [SLOT_W-1:0] pal_slot,
  output logic              pal_rgb,
  output logic [DATA_W-1:0] pal_wdata,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = SLOT_W + 1;
  localparam logic [4:0] OP_WRITE = 5'b10011;
  localparam logic [4:0] OP_BURST = 5'b10100;
  localparam logic [4:0] OP_CLEAR = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_BURST  = 2'd2,
    ST_CLEAR  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              rgb_q, rgb_d;
  logic [CNT_W-1:0]  colours_q, colours_d;
  logic              pal_we_q, pal_we_d;
  logic [SLOT_W-1:0] pal_slot_q, pal_slot_d;
  logic              pal_rgb_q, pal_rgb_d;
  logic [DATA_W-1:0] pal_wdata_q, pal_wdata_d;
  logic              done_q, done_d;
  logic              data_fire;

  assign cmd_ready  = (state_q == ST_IDLE);
  assign data_ready = (state_q == ST_SINGLE) || (state_q == ST_BURST);
  assign busy       = (state_q != ST_IDLE);
  assign data_fire  = data_valid && data_ready;

  assign pal_we    = pal_we_q;
  assign pal_slot  = pal_slot_q;
  assign pal_rgb   = pal_rgb_q;
  assign pal_wdata = pal_wdata_q;
  assign done      = done_q;

  // Next-state and write-port computation for every operation
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    rgb_d       = rgb_q;
    colours_d   = colours_q;
    pal_we_d    = 1'b0;
    pal_slot_d  = pal_slot_q;
    pal_rgb_d   = pal_rgb_q;
    pal_wdata_d = pal_wdata_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd[15:11])
            OP_WRITE: begin
              state_d = ST_SINGLE;
              slot_d  = cmd[6 +: SLOT_W];
              rgb_d   = cmd[5];
            end
            OP_BURST: begin
              state_d   = ST_BURST;
              slot_d    = cmd[6 +: SLOT_W];
              rgb_d     = 1'b0;
              colours_d = CNT_W'(cmd[4:0]) + CNT_W'(1);
            end
            OP_CLEAR: begin
              state_d = ST_CLEAR;
              slot_d  = {SLOT_W{1'b0}};
              rgb_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SINGLE: begin
        if (data_fire) begin
          pal_we_d    = 1'b1;
          pal_slot_d  = slot_q;
          pal_rgb_d   = rgb_q;
          pal_wdata_d = data;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_SINGLE;
        end
      end
      ST_BURST: begin
        if (data_fire) begin
          pal_we_d    = 1'b1;
          pal_slot_d  = slot_q;
          pal_rgb_d   = rgb_q;
          pal_wdata_d = data;
          rgb_d       = ~rgb_q;
          // A colour is complete once its BX half has been written
          if (rgb_q) begin
            slot_d    = slot_q + SLOT_W'(1);
            colours_d = colours_q - CNT_W'(1);
            if (colours_q == CNT_W'(1)) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_BURST;
            end
          end else begin
            state_d = ST_BURST;
          end
        end else begin
          state_d = ST_BURST;
        end
      end
      ST_CLEAR: begin
        pal_we_d    = 1'b1;
        pal_slot_d  = slot_q;
        pal_rgb_d   = rgb_q;
        pal_wdata_d = {DATA_W{1'b0}};
        rgb_d       = ~rgb_q;
        if (rgb_q) begin
          slot_d = slot_q + SLOT_W'(1);
          if (slot_q == {SLOT_W{1'b1}}) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_CLEAR;
          end
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered palette port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      slot_q      <= {SLOT_W{1'b0}};
      rgb_q       <= 1'b0;
      colours_q   <= {CNT_W{1'b0}};
      pal_we_q    <= 1'b0;
      pal_slot_q  <= {SLOT_W{1'b0}};
      pal_rgb_q   <= 1'b0;
      pal_wdata_q <= {DATA_W{1'b0}};
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      rgb_q       <= rgb_d;
      colours_q   <= colours_d;
      pal_we_q    <= pal_we_d;
      pal_slot_q  <= pal_slot_d;
      pal_rgb_q   <= pal_rgb_d;
      pal_wdata_q <= pal_wdata_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_palette_load_seq.sv
// Directed bench for palette_load_seq: an expected-write queue model plus
// literal spot checks on write, wrap, stall, clear, ignored opcodes and reset.
module tb_palette_load_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] data;
  logic        data_valid;
  logic        data_ready;
  logic        pal_we;
  logic [4:0]  pal_slot;
  logic        pal_rgb;
  logic [15:0] pal_wdata;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  palette_load_seq #(.DATA_W(16), .SLOT_W(5)) dut (
    .clk(clk), .rst(rst),
    .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .pal_we(pal_we), .pal_slot(pal_slot), .pal_rgb(pal_rgb),
    .pal_wdata(pal_wdata), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [4:0]  slot;
    logic        rgb;
    logic [15:0] wdata;
    logic        done;
  } wr_t;

  wr_t exp_q[$];
  wr_t log_a[0:511];
  wr_t cmp_e;
  int  wr_cnt  = 0;
  int  vectors = 0;
  int  errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: list every write an operation must produce, in order
  task automatic model_single(input int slot, input int rgb, input logic [15:0] d);
    wr_t e;
    e.slot = 5'(slot); e.rgb = 1'(rgb); e.wdata = d; e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic model_burst(input int start, input int colours, input int base);
    wr_t e;
    for (int i = 0; i < 2 * colours; i++) begin
      e.slot  = 5'((start + i / 2) % 32);
      e.rgb   = 1'(i % 2);
      e.wdata = 16'(base + i);
      e.done  = (i == 2 * colours - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic model_clear();
    wr_t e;
    for (int i = 0; i < 64; i++) begin
      e.slot = 5'(i / 2); e.rgb = 1'(i % 2); e.wdata = 16'h0000; e.done = (i == 63);
      exp_q.push_back(e);
    end
  endtask

  // Compare every palette write against the model queue
  always @(negedge clk) begin
    if (!rst) begin
      if (done) chk("done_has_we", {31'd0, pal_we}, 32'd1);
      if (pal_we) begin
        log_a[wr_cnt % 512] = {pal_slot, pal_rgb, pal_wdata, done};
        wr_cnt++;
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_write: actual slot=%0d rgb=%0d wdata=0x%0h expected no write at %0t",
                   pal_slot, pal_rgb, pal_wdata, $time);
        end else begin
          cmp_e = exp_q.pop_front();
          chk("write", {9'd0, pal_slot, pal_rgb, pal_wdata, done}, {9'd0, cmp_e});
        end
      end
    end
  end

  task automatic send_cmd(input logic [15:0] c, output int waited);
    @(negedge clk);
    cmd = c; cmd_valid = 1'b1; waited = 0;
    while (!cmd_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) chk("cmd_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic send_data(input logic [15:0] d);
    int n;
    @(negedge clk);
    data = d; data_valid = 1'b1; n = 0;
    while (!data_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("data_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1 data_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || pal_we) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int   w;
    int   base;
    int   cnt;
    int   first;
    logic gap;
    wr_t  lit[6];

    rst = 1'b1; cmd = 16'h0000; cmd_valid = 1'b0; data = 16'h0000; data_valid = 1'b0;
    #1;
    chk("rst_we", {31'd0, pal_we}, 32'd0);
    chk("rst_port", {10'd0, pal_slot, pal_rgb, pal_wdata}, 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single write: slot 19, BX half
    model_single(19, 1, 16'hABCD);
    send_cmd(16'h9CE0, w);
    send_data(16'hABCD);
    chk("write_lat_we", {31'd0, pal_we}, 32'd1);
    chk("write_lat_port", {10'd0, pal_slot, pal_rgb, pal_wdata}, {10'd0, 5'd19, 1'b1, 16'hABCD});
    chk("write_lat_done", {31'd0, done}, 32'd1);
    chk("write_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    chk("write_after_busy", {30'd0, busy, pal_we}, 32'd0);
    chk("write_hold_slot", {27'd0, pal_slot}, 32'd19);
    wait_drain();

    // Burst of 3 colours from slot 30, wrapping to slot 0
    lit[0] = {5'd30, 1'b0, 16'd1, 1'b0};
    lit[1] = {5'd30, 1'b1, 16'd2, 1'b0};
    lit[2] = {5'd31, 1'b0, 16'd3, 1'b0};
    lit[3] = {5'd31, 1'b1, 16'd4, 1'b0};
    lit[4] = {5'd0,  1'b0, 16'd5, 1'b0};
    lit[5] = {5'd0,  1'b1, 16'd6, 1'b1};
    base = wr_cnt;
    model_burst(30, 3, 1);
    send_cmd(16'hA782, w);
    for (int i = 1; i <= 6; i++) send_data(16'(i));
    wait_drain();
    chk("wrap_count", 32'(wr_cnt - base), 32'd6);
    for (int i = 0; i < 6; i++) chk("wrap_lit", {9'd0, log_a[(base + i) % 512]}, {9'd0, lit[i]});

    // Same burst with a 4-cycle data gap; cmd[5] set and must be ignored
    base = wr_cnt;
    model_burst(30, 3, 1);
    send_cmd(16'hA7A2, w);
    for (int i = 1; i <= 3; i++) send_data(16'(i));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k > 0) chk("stall_no_we", {31'd0, pal_we}, 32'd0);
    end
    for (int i = 4; i <= 6; i++) send_data(16'(i));
    wait_drain();
    chk("stall_count", 32'(wr_cnt - base), 32'd6);
    for (int i = 0; i < 6; i++) chk("stall_lit", {9'd0, log_a[(base + i) % 512]}, {9'd0, lit[i]});

    // Full clear: 64 back-to-back zero writes, data offered but never taken
    model_clear();
    send_cmd(16'hF800, w);
    data = 16'h5555; data_valid = 1'b1;
    cnt = 0; first = -1; gap = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (pal_we) begin
        if (first < 0) first = c;
        cnt++;
      end else if (first >= 0) begin
        gap = 1'b1;
      end
      if (done) break;
      if (c == 10) chk("clear_data_ready", {31'd0, data_ready}, 32'd0);
      if (c == 10 || c == 40) chk("clear_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    data_valid = 1'b0;
    chk("clear_writes", 32'(cnt), 32'd64);
    chk("clear_no_gap", {31'd0, gap}, 32'd0);
    wait_drain();

    // Hold and unknown opcodes are swallowed without side effects
    for (int j = 0; j < 2; j++) begin
      send_cmd((j == 0) ? 16'hC000 : 16'h0000, w);
      chk("ign_accept_wait", 32'(w), 32'd0);
      data = 16'h1234; data_valid = 1'b1;
      repeat (3) begin
        @(negedge clk);
        chk("ign_quiet", {29'd0, busy, data_ready, pal_we}, 32'd0);
      end
      data_valid = 1'b0;
    end

    // Reset in the middle of a 4-colour burst at slot 5
    model_burst(5, 4, 16'h0100);
    send_cmd(16'hA143, w);
    for (int i = 0; i < 3; i++) send_data(16'(16'h0100 + i));
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_port", {9'd0, pal_we, pal_slot, pal_rgb, pal_wdata}, 32'd0);
    chk("midrst_busy_done", {30'd0, busy, done}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    data = 16'h7777; data_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("postrst_idle", {29'd0, cmd_ready, data_ready, pal_we}, 32'd4);
    end
    data_valid = 1'b0;

    // Normal operation resumes after reset
    model_single(6, 0, 16'h2468);
    send_cmd(16'h9980, w);
    send_data(16'h2468);
    wait_drain();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
